// File: rtl/qsfp_sideband_ctrl.sv
// QSFP28 sideband sequencer: presence debounce, timed ResetL/init sequence, readiness and IntL latch.
// Optional interrupt latch is built only when QSFP_SB_INT_LATCH_EN is defined.
module qsfp_sideband_ctrl #(
  parameter int DEBOUNCE_CYCLES     = 125000,
  parameter int RESET_ASSERT_CYCLES = 1250,
  parameter int INIT_WAIT_CYCLES    = 250000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       qsfp_modprsl,
  input  logic       qsfp_intl,
  input  logic       soft_reset_req,
  input  logic       lpmode_req,
  input  logic       int_clear,
  output logic       qsfp_modsell,
  output logic       qsfp_resetl,
  output logic       qsfp_lpmode,
  output logic       module_present,
  output logic       module_ready,
  output logic       int_pending,
  output logic [1:0] sb_state
);

  // state     | meaning
  // ABSENT    | no debounced module, held in reset
  // RESET     | ResetL driven low for RESET_ASSERT_CYCLES
  // INIT_WAIT | ResetL released, waiting INIT_WAIT_CYCLES
  // READY     | module selected and usable
  localparam logic [1:0] ST_ABSENT = 2'd0;
  localparam logic [1:0] ST_RESET  = 2'd1;
  localparam logic [1:0] ST_INIT   = 2'd2;
  localparam logic [1:0] ST_READY  = 2'd3;

  localparam int MAX_PHASE = (RESET_ASSERT_CYCLES > INIT_WAIT_CYCLES) ?
                             RESET_ASSERT_CYCLES : INIT_WAIT_CYCLES;
  localparam int CNT_W = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_WAIT_CYCLES - 1);

  logic             r_prs_s1;
  logic             r_prs_s2;
  logic             r_prs_acc;
  logic [DB_W-1:0]  r_db_cnt;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_resetl;
  logic             r_lpmode;
  logic             r_modsell;
  logic             r_ready;
  logic [1:0]       w_state_nxt;
  logic             w_present;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prs_s1  <= 1'b1;
      r_prs_s2  <= 1'b1;
      r_prs_acc <= 1'b1;
      r_db_cnt  <= '0;
    end else begin
      r_prs_s1 <= qsfp_modprsl;
      r_prs_s2 <= r_prs_s1;
      if (r_prs_s2 == r_prs_acc) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_prs_acc <= r_prs_s2;
        r_db_cnt  <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  assign w_present = ~r_prs_acc;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ABSENT: if (w_present) w_state_nxt = ST_RESET;
      ST_RESET:  if (r_cnt == RST_LAST) w_state_nxt = ST_INIT;
      ST_INIT: begin
        if (soft_reset_req)          w_state_nxt = ST_RESET;
        else if (r_cnt == INIT_LAST) w_state_nxt = ST_READY;
      end
      ST_READY:  if (soft_reset_req) w_state_nxt = ST_RESET;
      default:   w_state_nxt = ST_ABSENT;
    endcase
    // Losing presence overrides every other transition.
    if (!w_present) w_state_nxt = ST_ABSENT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_ABSENT;
      r_cnt     <= '0;
      r_resetl  <= 1'b0;
      r_lpmode  <= 1'b1;
      r_modsell <= 1'b1;
      r_ready   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) begin
        r_cnt <= '0;
      end else if ((r_state == ST_RESET) || (r_state == ST_INIT)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_resetl  <= (w_state_nxt == ST_INIT) || (w_state_nxt == ST_READY);
      r_lpmode  <= (w_state_nxt == ST_READY) ? lpmode_req : 1'b1;
      r_modsell <= (w_state_nxt != ST_READY);
      r_ready   <= (w_state_nxt == ST_READY);
    end
  end

`ifdef QSFP_SB_INT_LATCH_EN
  logic r_int_s1;
  logic r_int_s2;
  logic r_int_d;
  logic r_int_pend;
  logic w_int_fall;

  assign w_int_fall = r_int_d & ~r_int_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int_s1   <= 1'b1;
      r_int_s2   <= 1'b1;
      r_int_d    <= 1'b1;
      r_int_pend <= 1'b0;
    end else begin
      r_int_s1 <= qsfp_intl;
      r_int_s2 <= r_int_s1;
      r_int_d  <= r_int_s2;
      if (w_state_nxt != ST_READY) begin
        r_int_pend <= 1'b0;
      end else if (w_int_fall && (r_state == ST_READY)) begin
        r_int_pend <= 1'b1;
      end else if (int_clear) begin
        r_int_pend <= 1'b0;
      end
    end
  end

  assign int_pending = r_int_pend;
`else
  logic w_unused_int;
  assign w_unused_int = qsfp_intl ^ int_clear;
  assign int_pending  = 1'b0;
`endif

  assign qsfp_modsell   = r_modsell;
  assign qsfp_resetl    = r_resetl;
  assign qsfp_lpmode    = r_lpmode;
  assign module_present = w_present;
  assign module_ready   = r_ready;
  assign sb_state       = r_state;

endmodule

// File: doc/qsfp_sideband_ctrl.md
# qsfp_sideband_ctrl

Sequences and monitors the QSFP28 low-speed sideband pins (ModSelL, ResetL, LPMode, ModPrsL, IntL) between the FPGA pins and the NTP server core. The block debounces module presence, drives a timed reset and initialisation sequence on insertion or on request, and reports module readiness and latched interrupts to the core. One instance per QSFP cage sits beside the MAC/PHY instances in the top level.

## Interface

- DEBOUNCE_CYCLES, 125000: consecutive stable cycles needed to accept a ModPrsL change (1 ms at 125 MHz).
- RESET_ASSERT_CYCLES, 1250: ResetL low time (10 us).
- INIT_WAIT_CYCLES, 250000000: wait after ResetL release before ready (2 s).
- clk  in  1  system clock (125 MHz).
- rst_n  in  1  asynchronous active-low reset.
- qsfp_modprsl  in  1  module present, active low, asynchronous to clk.
- qsfp_intl  in  1  module interrupt, active low, asynchronous to clk.
- soft_reset_req  in  1  single-cycle pulse requesting a module reset.
- lpmode_req  in  1  level, 1 = request low-power mode while ready.
- int_clear  in  1  single-cycle pulse clearing int_pending.
- qsfp_modsell  out  1  module select, active low.
- qsfp_resetl  out  1  module reset, active low.
- qsfp_lpmode  out  1  module low-power mode.
- module_present  out  1  debounced presence.
- module_ready  out  1  module initialised and usable.
- int_pending  out  1  latched interrupt.
- sb_state  out  2  FSM state: 0 ABSENT, 1 RESET, 2 INIT_WAIT, 3 READY.

## Operation

- qsfp_modprsl and qsfp_intl each pass a 2-flop synchroniser before use.
- Debouncer: counter reloads on any change of the synchronised ModPrsL versus the accepted value; when it reaches DEBOUNCE_CYCLES-1 with the input still different, the accepted value updates. module_present = ~accepted.
- FSM:
  - ABSENT: on module_present rising -> RESET.
  - RESET: count RESET_ASSERT_CYCLES, then -> INIT_WAIT.
  - INIT_WAIT: count INIT_WAIT_CYCLES, then -> READY.
  - READY: holds.
  - From RESET, INIT_WAIT or READY: module_present low -> ABSENT (priority over all else).
  - soft_reset_req in INIT_WAIT or READY -> RESET, counter restarts. Ignored in ABSENT and RESET.
- Outputs, all registered, decoded from next state:
  - qsfp_resetl = 0 in ABSENT and RESET, else 1.
  - qsfp_lpmode = 1 except in READY, where it equals lpmode_req.
  - qsfp_modsell = 0 only in READY.
  - module_ready = 1 only in READY.
- Single shared phase counter, width $clog2 of the largest of RESET_ASSERT_CYCLES and INIT_WAIT_CYCLES; it clears on every state entry and never wraps.

## Timing

- Reset values: qsfp_resetl=0, qsfp_lpmode=1, qsfp_modsell=1, module_present=0, module_ready=0, int_pending=0, sb_state=0, accepted presence = absent.
- Pin to accepted presence: 2 sync cycles + DEBOUNCE_CYCLES.
- module_present rises in cycle N -> sb_state=1 and qsfp_resetl=0 from N+1.
- qsfp_resetl stays low exactly RESET_ASSERT_CYCLES cycles in RESET.
- qsfp_resetl rises on INIT_WAIT entry; module_ready rises exactly INIT_WAIT_CYCLES cycles later.
- lpmode_req to qsfp_lpmode in READY: 1 cycle.
- rst_n low mid-sequence: all outputs return to reset values immediately. After release, the sequence restarts from debounce.

## Configuration

- QSFP_SB_INT_LATCH_EN defined:
  - A falling edge of synchronised IntL while in READY sets int_pending.
  - int_clear clears it; if a set and int_clear occur in the same cycle, set wins.
  - int_pending clears on leaving READY.
  - Pin-to-int_pending latency: 3 cycles.
- Not defined: int_pending is constant 0 and qsfp_intl is unused; no synchroniser is built.

## Test plan

- Parameters for all scenarios: DEBOUNCE=4, RESET=3, INIT=5.
- Insertion: drive modprsl 1->0 and hold -> module_present=1 after 6 cycles; resetl low 3 cycles; module_ready=1 5 cycles after resetl rises; modsell=0 and lpmode=lpmode_req.
- Glitch rejection: pulse modprsl low for 3 cycles -> module_present stays 0; sb_state stays 0.
- Removal during INIT_WAIT: modprsl high, held -> ABSENT 6 cycles later; resetl=0, lpmode=1, modsell=1, module_ready=0.
- soft_reset_req in READY -> next cycle sb_state=1, resetl=0, module_ready=0; full 3+5 cycle sequence repeats.
- Interrupt (macro on): in READY, intl 1->0 -> int_pending=1 after 3 cycles. int_clear together with a new falling edge -> int_pending stays 1. int_clear alone -> 0 next cycle.
- Async reset: assert rst_n low mid-RESET -> all outputs return to reset values without a clock edge.
